serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_fs.sv | 22 ++
 rtl/serial_subtractor.sv | 168 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor: the controller state
// encoding and the default operand width.
// Ports: none (package).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor
// One-bit combinational full subtractor. The serial subtractor uses a single
// instance of it and feeds it a new bit pair every BUSY cycle.
// Ports:
//   a, b        : minuend and subtrahend bits
//   borrow_in   : borrow from the next-lower bit position
//   diff        : difference bit
//   borrow_out  : borrow into the next-higher bit position
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  // Borrow when b exceeds a outright, or when the bits are equal and a borrow
  // is already pending from below.
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor computing (a - b - borrow_in) mod 2^WIDTH,
// one bit per clock, LSB first, with valid/ready handshakes on both sides.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the 'overflow'
// output (signed two's-complement overflow, valid with out_valid).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : operand set on a/b/borrow_in is valid
//   in_ready     : block can accept operands (IDLE only)
//   a, b         : minuend, subtrahend (WIDTH bits)
//   borrow_in    : incoming borrow
//   out_valid    : result valid (DONE only)
//   out_ready    : consumer accepts the result
//   diff         : difference (WIDTH bits)
//   borrow_out   : set when a < b + borrow_in (unsigned)
//   overflow     : signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [WIDTH-1:0] LAST_BIT = WIDTH'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             borrow_out_q, borrow_out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  logic fs_diff;
  logic fs_borrow;

  full_subtractor u_fs (
    .a          (a_sh_q[0]),
    .b          (b_sh_q[0]),
    .borrow_in  (br_q),
    .diff       (fs_diff),
    .borrow_out (fs_borrow)
  );

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    br_d         = br_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_out_d = borrow_out_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    overflow_d   = overflow_q;
`endif

    case (state_q)
      IDLE: begin
        // in_ready is always high in IDLE, so in_valid alone means accept.
        if (in_valid) begin
          state_d    = BUSY;
          a_sh_d     = a;
          b_sh_d     = b;
          br_d       = borrow_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end

      BUSY: begin
        // Operands shift right so bit 0 always feeds the full subtractor;
        // result bits enter at the MSB and reach their place after WIDTH shifts.
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = fs_borrow;
        diff_d = {fs_diff, diff_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          borrow_out_d = fs_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // On the last bit-cycle a_sh_q[0]/b_sh_q[0] are the operand MSBs
          // and fs_diff is the result MSB.
          overflow_d = (a_sh_q[0] != b_sh_q[0]) & (fs_diff != a_sh_q[0]);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Returning to IDLE here means no accept can coincide with consume.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      br_q         <= 1'b0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      br_q         <= br_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_out_q <= borrow_out_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor (WIDTH=4): directed cases, a
// backpressure hold, a reset in the middle of an operation, then randomized
// operands with random consumer backpressure. Expected results come from
// integer arithmetic on the operands.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    int               acceptCyc;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;
  bit   readyForceLow = 1'b0;
  bit   randomReady   = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference: plain signed integer subtraction, wrapped to WIDTH bits.
  function automatic exp_t model(input logic [WIDTH-1:0] ai,
                                 input logic [WIDTH-1:0] bv,
                                 input logic br, input int acc);
    exp_t e;
    int r;
    logic [WIDTH-1:0] d;
    r = int'(ai) - int'(bv) - int'(br);
    d = r[WIDTH-1:0];
    e.diff      = d;
    e.borrow    = (r < 0);
    e.ovf       = (ai[WIDTH-1] != bv[WIDTH-1]) && (d[WIDTH-1] != ai[WIDTH-1]);
    e.acceptCyc = acc;
    return e;
  endfunction

  // Consumer: drives out_ready a little after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (readyForceLow) out_ready = 1'b0;
      else if (randomReady) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  initial begin : monitor_proc
    exp_t e;
    bit   prevValid;
    bit   prevConsume;
    prevValid   = 1'b0;
    prevConsume = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid   = 1'b0;
        prevConsume = 1'b0;
      end else begin
        if (prevConsume) begin
          checkOutput("in_ready after consume", in_ready, 1);
          checkOutput("out_valid after consume", out_valid, 0);
        end
        prevConsume = 1'b0;
        if (out_valid) begin
          if (expQ.size() == 0) begin
            reportFail("out_valid with empty scoreboard");
          end else begin
            e = expQ[0];
            if (!prevValid) checkOutput("latency", cyc - e.acceptCyc, WIDTH);
            checkOutput("diff", diff, e.diff);
            checkOutput("borrow_out", borrow_out, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
            checkOutput("overflow", overflow, e.ovf);
`endif
            checkOutput("in_ready low in DONE", in_ready, 0);
            if (out_ready) begin
              void'(expQ.pop_front());
              prevConsume = 1'b1;
            end
          end
        end
        prevValid = out_valid;
      end
    end
  end

  // Presents one operand set and returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ai,
                               input logic [WIDTH-1:0] bv, input logic br);
    int guard = 0;
    a = ai;
    b = bv;
    borrow_in = br;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      reportFail("accept timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    expQ.push_back(model(ai, bv, br, cyc));
    in_valid  = 1'b0;
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    borrow_in = 1'($urandom);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((expQ.size() != 0 || !in_ready) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (expQ.size() != 0 || !in_ready) reportFail("drain timeout");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    borrow_in = 1'b0;
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset borrow_out", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput("reset overflow", overflow, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", in_ready, 1);
    @(posedge clk);
    #1;

    applyStimulus(4'd9, 4'd3, 1'b0);
    waitIdle();
    applyStimulus(4'd3, 4'd9, 1'b0);
    waitIdle();
    applyStimulus(4'd0, 4'd0, 1'b1);
    waitIdle();
    applyStimulus(4'd8, 4'd1, 1'b0);
    waitIdle();

    // Backpressure: hold the result for three cycles while inputs toggle.
    readyForceLow = 1'b1;
    applyStimulus(4'd6, 4'd11, 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!out_valid) reportFail("backpressure out_valid timeout");
    repeat (3) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    readyForceLow = 1'b0;
    waitIdle();

    // Reset during BUSY bit-cycle 2 discards the operation.
    applyStimulus(4'd12, 4'd5, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("mid-op reset out_valid", out_valid, 0);
    checkOutput("mid-op reset diff", diff, 0);
    checkOutput("mid-op reset borrow_out", borrow_out, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after mid-op reset", in_ready, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'd5, 4'd5, 1'b0);
    waitIdle();

    // Randomized operands with random consumer backpressure.
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    randomReady = 1'b0;
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
